// File: rtl/data_cache_way_array.sv
// L1 data cache storage for all ways: valid/dirty/tag per line, data per word.
// Port 0 is read/write for the controller. Port 1 is a read-only tag lookup.
// A sweeper clears valid/dirty after reset or on invalidate_i.
// Ports:
//   clk_i, rst_n_i      clock, async active-low reset
//   invalidate_i        start a full valid/dirty sweep
//   ready_o             1 when the sweeper is idle
//   port0_*_i / _o      controller access, 1-cycle read latency, read-first
//   port1_*_i / _o      lookup with tag compare, 1-cycle latency
module data_cache_way_array #(
    parameter int WAYS        = 4,
    parameter int SETS        = 256,
    parameter int BLOCK_WORDS = 4,
    parameter int TAG_WIDTH   = 20,
    parameter int WORD_WIDTH  = 32,
    localparam int IDX_W = $clog2(SETS),
    localparam int OFF_W = (BLOCK_WORDS > 1) ? $clog2(BLOCK_WORDS) : 1,
    localparam int WAY_W = $clog2(WAYS),
    localparam int BYTES = WORD_WIDTH / 8
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic                  invalidate_i,
    output logic                  ready_o,
    input  logic [WAYS-1:0]       port0_way_i,
    input  logic [3:0]            port0_enable_i,
    input  logic [IDX_W-1:0]      port0_index_i,
    input  logic [OFF_W-1:0]      port0_offset_i,
    input  logic [BYTES-1:0]      port0_byte_write_i,
    input  logic                  port0_write_i,
    input  logic                  port0_read_i,
    input  logic                  port0_valid_i,
    input  logic                  port0_dirty_i,
    input  logic [TAG_WIDTH-1:0]  port0_tag_i,
    input  logic [WORD_WIDTH-1:0] port0_word_i,
    output logic                  port0_valid_o,
    output logic                  port0_dirty_o,
    output logic [TAG_WIDTH-1:0]  port0_tag_o,
    output logic [WORD_WIDTH-1:0] port0_word_o,
    input  logic                  port1_read_i,
    input  logic [IDX_W-1:0]      port1_index_i,
    input  logic [OFF_W-1:0]      port1_offset_i,
    input  logic [TAG_WIDTH-1:0]  port1_tag_i,
    output logic                  port1_data_valid_o,
    output logic                  port1_hit_o,
    output logic [WAY_W-1:0]      port1_hit_way_o,
    output logic                  port1_dirty_o,
    output logic [WORD_WIDTH-1:0] port1_word_o
);

    // Field enable bit positions in port0_enable_i.
    localparam int EN_VALID = 0;
    localparam int EN_DIRTY = 1;
    localparam int EN_TAG   = 2;
    localparam int EN_DATA  = 3;

    typedef enum logic {
        ST_IDLE,
        ST_SWEEP
    } state_e;

    state_e           state_q, state_d;
    logic [IDX_W-1:0] sweep_q, sweep_d;

    logic valid_q [WAYS][SETS];
    logic dirty_q [WAYS][SETS];
    logic [TAG_WIDTH-1:0]  tag_q  [WAYS][SETS];
    logic [WORD_WIDTH-1:0] data_q [WAYS][SETS][BLOCK_WORDS];

    logic            sweeping;
    logic            rd0;
    logic            rd1;
    logic [WAYS-1:0] wr_way;
    logic [WAYS-1:0] fwd_line;
    logic [WAYS-1:0] fwd_word;

    // ---------------- sweeper FSM ----------------
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= ST_SWEEP;
            sweep_q <= '0;
        end else begin
            state_q <= state_d;
            sweep_q <= sweep_d;
        end
    end

    always_comb begin
        state_d = state_q;
        sweep_d = sweep_q;
        case (state_q)
            ST_IDLE: begin
                if (invalidate_i) begin
                    state_d = ST_SWEEP;
                    sweep_d = '0;
                end
            end
            ST_SWEEP: begin
                sweep_d = sweep_q + 1'b1;
                if (sweep_q == IDX_W'(SETS - 1)) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_SWEEP;
        endcase
    end

    assign ready_o  = (state_q == ST_IDLE);
    assign sweeping = (state_q == ST_SWEEP);
    assign rd0      = port0_read_i & ready_o;
    assign rd1      = port1_read_i & ready_o;
    assign wr_way   = port0_way_i & {WAYS{port0_write_i & ready_o}};

    // Port 0 writes that hit the line / word port 1 is looking up now.
    assign fwd_line = wr_way & {WAYS{port0_index_i == port1_index_i}};
    assign fwd_word = fwd_line & {WAYS{port0_enable_i[EN_DATA] &&
                      (port0_offset_i == port1_offset_i)}};

    // ---------------- storage ----------------
    always_ff @(posedge clk_i) begin
        for (int w = 0; w < WAYS; w++) begin
            if (sweeping) begin
                valid_q[w][sweep_q] <= 1'b0;
                dirty_q[w][sweep_q] <= 1'b0;
            end else if (wr_way[w]) begin
                if (port0_enable_i[EN_VALID]) begin
                    valid_q[w][port0_index_i] <= port0_valid_i;
                end
                if (port0_enable_i[EN_DIRTY]) begin
                    dirty_q[w][port0_index_i] <= port0_dirty_i;
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        for (int w = 0; w < WAYS; w++) begin
            if (wr_way[w] && port0_enable_i[EN_TAG]) begin
                tag_q[w][port0_index_i] <= port0_tag_i;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        for (int w = 0; w < WAYS; w++) begin
            for (int b = 0; b < BYTES; b++) begin
                if (wr_way[w] && port0_enable_i[EN_DATA] &&
                    port0_byte_write_i[b]) begin
                    data_q[w][port0_index_i][port0_offset_i][8*b +: 8]
                        <= port0_word_i[8*b +: 8];
                end
            end
        end
    end

    // ---------------- port 0 read ----------------
    logic                  p0_valid;
    logic                  p0_dirty;
    logic [TAG_WIDTH-1:0]  p0_tag;
    logic [WORD_WIDTH-1:0] p0_word;

    // One-hot select done as an AND-OR mux.
    always_comb begin
        p0_valid = 1'b0;
        p0_dirty = 1'b0;
        p0_tag   = '0;
        p0_word  = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (port0_way_i[w]) begin
                p0_valid |= valid_q[w][port0_index_i];
                p0_dirty |= dirty_q[w][port0_index_i];
                p0_tag   |= tag_q[w][port0_index_i];
                p0_word  |= data_q[w][port0_index_i][port0_offset_i];
            end
        end
    end

    logic                  port0_valid_q;
    logic                  port0_dirty_q;
    logic [TAG_WIDTH-1:0]  port0_tag_q;
    logic [WORD_WIDTH-1:0] port0_word_q;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            port0_valid_q <= 1'b0;
            port0_dirty_q <= 1'b0;
            port0_tag_q   <= '0;
            port0_word_q  <= '0;
        end else if (rd0) begin
            port0_valid_q <= p0_valid;
            port0_dirty_q <= p0_dirty;
            port0_tag_q   <= p0_tag;
            port0_word_q  <= p0_word;
        end
    end

    assign port0_valid_o = port0_valid_q;
    assign port0_dirty_o = port0_dirty_q;
    assign port0_tag_o   = port0_tag_q;
    assign port0_word_o  = port0_word_q;

    // ---------------- port 1 lookup ----------------
    logic [WAYS-1:0]       p1_valid;
    logic [WAYS-1:0]       p1_dirty;
    logic [WAYS-1:0]       p1_match;
    logic [TAG_WIDTH-1:0]  p1_tag  [WAYS];
    logic [WORD_WIDTH-1:0] p1_word [WAYS];
    logic                  p1_hit;
    logic [WAY_W-1:0]      p1_way;
    logic                  p1_hdirty;
    logic [WORD_WIDTH-1:0] p1_hword;

    // Per-way view of the line after any same-cycle port 0 write.
    always_comb begin
        p1_valid = '0;
        p1_dirty = '0;
        p1_match = '0;
        p1_tag   = '{default: '0};
        p1_word  = '{default: '0};
        for (int w = 0; w < WAYS; w++) begin
            p1_valid[w] = (fwd_line[w] && port0_enable_i[EN_VALID])
                        ? port0_valid_i : valid_q[w][port1_index_i];
            p1_dirty[w] = (fwd_line[w] && port0_enable_i[EN_DIRTY])
                        ? port0_dirty_i : dirty_q[w][port1_index_i];
            p1_tag[w]   = (fwd_line[w] && port0_enable_i[EN_TAG])
                        ? port0_tag_i : tag_q[w][port1_index_i];
            p1_word[w]  = data_q[w][port1_index_i][port1_offset_i];
            for (int b = 0; b < BYTES; b++) begin
                if (fwd_word[w] && port0_byte_write_i[b]) begin
                    p1_word[w][8*b +: 8] = port0_word_i[8*b +: 8];
                end
            end
            p1_match[w] = p1_valid[w] && (p1_tag[w] == port1_tag_i);
        end
    end

    // Descending scan so the lowest matching way wins.
    always_comb begin
        p1_hit    = 1'b0;
        p1_way    = '0;
        p1_hdirty = 1'b0;
        p1_hword  = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (p1_match[w]) begin
                p1_hit    = 1'b1;
                p1_way    = WAY_W'(w);
                p1_hdirty = p1_dirty[w];
                p1_hword  = p1_word[w];
            end
        end
    end

    logic                  port1_data_valid_q;
    logic                  port1_hit_q;
    logic [WAY_W-1:0]      port1_hit_way_q;
    logic                  port1_dirty_q;
    logic [WORD_WIDTH-1:0] port1_word_q;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            port1_data_valid_q <= 1'b0;
            port1_hit_q        <= 1'b0;
            port1_hit_way_q    <= '0;
            port1_dirty_q      <= 1'b0;
            port1_word_q       <= '0;
        end else begin
            port1_data_valid_q <= rd1;
            if (rd1) begin
                port1_hit_q     <= p1_hit;
                port1_hit_way_q <= p1_way;
                port1_dirty_q   <= p1_hdirty;
                port1_word_q    <= p1_hword;
            end
        end
    end

    assign port1_data_valid_o = port1_data_valid_q;
    assign port1_hit_o        = port1_hit_q;
    assign port1_hit_way_o    = port1_hit_way_q;
    assign port1_dirty_o      = port1_dirty_q;
    assign port1_word_o       = port1_word_q;

    // ---------------- checks ----------------
    a_p0_onehot : assert property (@(posedge clk_i) disable iff (!rst_n_i)
        rd0 |-> $onehot(port0_way_i));

    a_p1_multihit : assert property (@(posedge clk_i) disable iff (!rst_n_i)
        rd1 |-> $onehot0(p1_match));

endmodule

// File: doc/data_cache_way_array.md
Name: data_cache_way_array

Overview:
Parametrised successor to the single data cache way. One instance holds every way of the L1 data cache: status (valid/dirty), tag and data memories, arranged as WAYS x SETS x BLOCK_WORDS. Port 0 is read/write for the cache controller (fill, store, writeback). Port 1 is read-only for the load pipe, with a built-in tag compare and hit-way select. Adds a self-clearing invalidate sweeper after reset or on request, plus write-to-read collision forwarding.

Parameters:
WAYS, 4, number of ways (power of 2, >=2)
SETS, 256, sets per way (power of 2)
BLOCK_WORDS, 4, words per cache line (power of 2)
TAG_WIDTH, 20, tag bits
WORD_WIDTH, 32, data word bits (multiple of 8)

Ports:
clk_i  in  1  clock
rst_n_i  in  1  asynchronous active-low reset
invalidate_i  in  1  pulse: clear valid+dirty of all lines
ready_o  out  1  1 = sweeper idle, accesses accepted
port0_way_i  in  WAYS  one-hot way select for port 0
port0_enable_i  in  4  field enables {data,tag,dirty,valid}
port0_index_i  in  log2(SETS)  set index
port0_offset_i  in  log2(BLOCK_WORDS)  word in line
port0_byte_write_i  in  WORD_WIDTH/8  byte enables for data write
port0_write_i  in  1  write strobe
port0_read_i  in  1  read strobe
port0_valid_i / port0_dirty_i  in  1  status write data
port0_tag_i  in  TAG_WIDTH  tag write data
port0_word_i  in  WORD_WIDTH  data write word
port0_valid_o  out  1  valid bit of selected way (registered)
port0_dirty_o  out  1  dirty bit of selected way (registered)
port0_tag_o  out  TAG_WIDTH  tag of selected way (registered)
port0_word_o  out  WORD_WIDTH  data of selected way (registered)
port1_read_i  in  1  lookup strobe
port1_index_i  in  log2(SETS)  lookup set
port1_offset_i  in  log2(BLOCK_WORDS)  lookup word
port1_tag_i  in  TAG_WIDTH  lookup tag
port1_data_valid_o  out  1  lookup result valid
port1_hit_o  out  1  tag match on a valid way
port1_hit_way_o  out  log2(WAYS)  matching way
port1_dirty_o  out  1  dirty bit of hit way
port1_word_o  out  WORD_WIDTH  data of hit way

Behaviour:
- Reset (async assert, sync release): all registered outputs 0. FSM enters SWEEP with sweep index 0. ready_o=0.
- FSM IDLE: ready_o=1. invalidate_i=1 -> SWEEP, index 0, ready_o=0 next cycle. A port access in that same cycle is still performed.
- FSM SWEEP: each cycle clears valid and dirty of set[index] in all ways, then index++. Tag and data are untouched. At index SETS-1 -> IDLE. Sweep takes exactly SETS cycles.
- invalidate_i during SWEEP is ignored.
- Reset mid-sweep restarts the sweep at index 0.
- While ready_o=0: port0 writes dropped, reads ignored; port1_data_valid_o=0.
- Port 0 write: for each way with port0_way_i bit set, writes the enabled fields. Data is byte-masked by port0_byte_write_i. Status/tag are per line, data is per word (offset).
- Port 0 read: 1-cycle latency; outputs come from the way selected by port0_way_i. Non-one-hot port0_way_i on read is illegal (assertion).
- Port 0 read and write in the same cycle: read returns old contents (read-first).
- Port 1: 1-cycle latency. port1_data_valid_o = registered (port1_read_i & ready_o).
  - Hit = OR over ways of (valid & tag==port1_tag_i).
  - hit_way = lowest matching way index. Multi-hit is flagged by an assertion only.
  - On miss: hit_o=0, hit_way_o=0, dirty_o=0, word_o=0.
- Collision (port0 write and port1 read to same index in same cycle): port1 sees post-write state.
  - Status/tag of written ways are forwarded.
  - If offsets match, the word is byte-merged: new bytes where byte_write=1, old bytes elsewhere.
- Outputs hold their last value when no read is issued (except port1_data_valid_o, which drops to 0).

Test Plan:
- Reset release, SETS=256 -> ready_o low exactly 256 cycles, then 1. Lookup of any set afterwards -> hit_o=0.
- Port 0 fill way 2, set 5, tag 0x12345, valid=1, offsets 0..3 = 0xA0..0xA3. Then port1 lookup set 5, offset 2, tag 0x12345 -> cycle+1: valid=1, hit=1, hit_way=2, word=0xA2.
- Same-cycle port0 write (way 2, set 5, offset 1, byte_write=0b0011, word 0xFFFF_BEEF) and port1 read (set 5, offset 1), old word 0x0000_00A1 -> port1_word_o=0x0000_BEEF.
- Lines valid in ways 1 and 3 with different tags; lookup tag of way 3 -> hit_way=3. Lookup with a non-matching tag -> hit=0, word=0.
- invalidate_i in IDLE with a port0 write issued 3 cycles later -> write dropped, ready_o low 256 cycles, all previous hits now miss.
- rst_n_i asserted at sweep index 100 -> outputs 0 immediately; after release the sweep runs a full 256 cycles from 0.
